// File: rtl/asym_fifo_pkg.sv
// Shared types and helpers for the asymmetric (wide-write, narrow-read) FIFO.
// Imported by asym_fifo_ctrl and asym_fifo.
package asym_fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RD,
        OP_WR,
        OP_RW
    } fifo_op_t;

    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/asym_fifo_ctrl.sv
// Pointer, occupancy and flag control for asym_fifo.
// ASYM_FIFO_LEVEL_EN adds level / almost_full / almost_empty outputs.
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int RATIO      = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int ALMOST_GAP = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_err,
    output logic                  rd_err
`ifdef ASYM_FIFO_LEVEL_EN
   ,output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         RATIO_C = CW'(RATIO);
    // RATIO == DEPTH truncates to 0, which is the correct modular step
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(RATIO);

    if (ALMOST_GAP < 0) begin : g_bad_gap
        $error("asym_fifo_ctrl: ALMOST_GAP must be non-negative");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         free;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_op_t              op;

    assign free  = DEPTH_C - count;
    assign full  = free < RATIO_C;
    assign empty = count == '0;

    // Both requests judged on pre-cycle state only
    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    always_comb begin
        op = OP_NONE;
        unique case ({wr_acc, rd_acc})
            2'b01:   op = OP_RD;
            2'b10:   op = OP_WR;
            2'b11:   op = OP_RW;
            default: op = OP_NONE;
        endcase
    end

    always_comb begin
        count_next = count;
        unique case (op)
            OP_RD:   count_next = count - CW'(1);
            OP_WR:   count_next = count + RATIO_C;
            OP_RW:   count_next = count + RATIO_C - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + STEP_C;
            if (rd_acc)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count  <= count_next;
            wr_err <= wr && full;
            rd_err <= rd && empty;
        end
    end

    assign w_addr = wr_ptr;
    assign r_addr = rd_ptr;
    assign wr_en  = wr_acc;

`ifdef ASYM_FIFO_LEVEL_EN
    assign level        = count;
    assign almost_full  = 32'(free) <= ALMOST_GAP;
    assign almost_empty = count < RATIO_C;
`endif

endmodule

// File: rtl/asym_fifo.sv
// Width-converting FIFO: RATIO-lane write word in, one lane out (FWFT).
// ASYM_FIFO_LEVEL_EN exposes level, almost_full and almost_empty.
module asym_fifo
    import asym_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int ALMOST_GAP = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr,
    input  logic [DATA_WIDTH*RATIO-1:0] w_data,
    input  logic                        rd,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        full,
    output logic                        empty,
    output logic                        wr_err,
    output logic                        rd_err
`ifdef ASYM_FIFO_LEVEL_EN
   ,output logic [ADDR_WIDTH:0]         level,
    output logic                        almost_full,
    output logic                        almost_empty
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!is_pow2(RATIO) || RATIO > DEPTH) begin : g_bad_ratio
        $error("asym_fifo: RATIO must be a power of 2 and <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    asym_fifo_ctrl #(
        .RATIO      (RATIO),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ALMOST_GAP (ALMOST_GAP)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .wr_en        (wr_en),
        .full         (full),
        .empty        (empty),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
`ifdef ASYM_FIFO_LEVEL_EN
       ,.level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // w_addr is RATIO-aligned, so lanes never straddle the wrap point
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < RATIO; i++)
                mem[w_addr + ADDR_WIDTH'(i)] <= w_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: tb/tb_asym_fifo.sv
// Self-checking bench for asym_fifo against a queue-based reference model.
// Works with or without ASYM_FIFO_LEVEL_EN.
module tb_asym_fifo;

    localparam int DW    = 8;
    localparam int RATIO = 2;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wr = 1'b0;
    logic                rd = 1'b0;
    logic [DW*RATIO-1:0] w_data = '0;
    logic [DW-1:0]       r_data;
    logic                full;
    logic                empty;
    logic                wr_err;
    logic                rd_err;
`ifdef ASYM_FIFO_LEVEL_EN
    logic [AW:0]         level;
    logic                almost_full;
    logic                almost_empty;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    asym_fifo #(
        .DATA_WIDTH (DW),
        .RATIO      (RATIO),
        .ADDR_WIDTH (AW),
        .ALMOST_GAP (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
`ifdef ASYM_FIFO_LEVEL_EN
       ,.level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int n;
        n = q.size();
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'((DEPTH - n) < RATIO));
        if (n != 0)
            chk("r_data", 32'(r_data), 32'(q[0]));
`ifdef ASYM_FIFO_LEVEL_EN
        chk("level", 32'(level), 32'(n));
        chk("almost_full", 32'(almost_full), 32'((DEPTH - n) <= 2));
        chk("almost_empty", 32'(almost_empty), 32'(n < RATIO));
`endif
    endtask

    // Called at a negedge; applies one cycle of requests and checks after it
    task automatic do_cycle(input logic w, input logic [DW*RATIO-1:0] d,
                            input logic r);
        logic wacc, racc;
        logic [DW*RATIO-1:0] word;
        wr = w;
        rd = r;
        w_data = d;
        wacc = w && ((DEPTH - q.size()) >= RATIO);
        racc = r && (q.size() != 0);
        if (racc)
            void'(q.pop_front());
        word = d;
        if (wacc)
            for (int i = 0; i < RATIO; i++)
                q.push_back(word[i*DW +: DW]);
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        chk("wr_err", 32'(wr_err), 32'(w && !wacc));
        chk("rd_err", 32'(rd_err), 32'(r && !racc));
        check_status();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 2 * DEPTH) begin
            do_cycle(1'b0, '0, 1'b1);
            guard++;
        end
        chk("drain_empty", 32'(empty), 32'(1));
    endtask

    initial begin
        // 1: reset state and read-while-empty
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_wr_err", 32'(wr_err), 32'(0));
        chk("rst_rd_err", 32'(rd_err), 32'(0));
        check_status();
        do_cycle(1'b0, '0, 1'b0);
        do_cycle(1'b0, '0, 1'b1);
        chk("t1_rd_err", 32'(rd_err), 32'(1));
        do_cycle(1'b0, '0, 1'b0);
        chk("t1_rd_err_clear", 32'(rd_err), 32'(0));

        // 2: one wide word, lane order, then underflow
        do_cycle(1'b1, 16'hBBAA, 1'b0);
        chk("t2_lane0", 32'(r_data), 32'h0000_00AA);
        do_cycle(1'b0, '0, 1'b1);
        chk("t2_lane1", 32'(r_data), 32'h0000_00BB);
        do_cycle(1'b0, '0, 1'b1);
        chk("t2_empty", 32'(empty), 32'(1));
        do_cycle(1'b0, '0, 1'b1);
        chk("t2_rd_err", 32'(rd_err), 32'(1));

        // 3: fill, overflow, full release threshold
        do_cycle(1'b1, 16'h0201, 1'b0);
        do_cycle(1'b1, 16'h0403, 1'b0);
        do_cycle(1'b1, 16'h0605, 1'b0);
        do_cycle(1'b1, 16'h0807, 1'b0);
        chk("t3_full", 32'(full), 32'(1));
        do_cycle(1'b1, 16'hEEEE, 1'b0);
        chk("t3_wr_err", 32'(wr_err), 32'(1));
        chk("t3_kept", 32'(r_data), 32'h0000_0001);
        do_cycle(1'b0, '0, 1'b1);
        chk("t3_full_free1", 32'(full), 32'(1));
        do_cycle(1'b0, '0, 1'b1);
        chk("t3_full_free2", 32'(full), 32'(0));
        drain();

        // 4: simultaneous read/write near full
        do_cycle(1'b1, 16'h1211, 1'b0);
        do_cycle(1'b1, 16'h1413, 1'b0);
        do_cycle(1'b1, 16'h1615, 1'b0);
        do_cycle(1'b1, 16'h1817, 1'b1);
        chk("t4_rw_ok_wr_err", 32'(wr_err), 32'(0));
        chk("t4_count7", 32'(q.size()), 32'(7));
        do_cycle(1'b1, 16'h1A19, 1'b1);
        chk("t4_rw_full_wr_err", 32'(wr_err), 32'(1));
        chk("t4_count6", 32'(q.size()), 32'(6));
        drain();

        // 5: write and read together while empty
        do_cycle(1'b1, 16'hCDAB, 1'b1);
        chk("t5_rd_err", 32'(rd_err), 32'(1));
        chk("t5_r_data", 32'(r_data), 32'h0000_00AB);
        drain();

        // 6: random interleaved stream across wrap
        for (int i = 0; i < 120; i++)
            do_cycle(1'($urandom_range(0, 2) == 0),
                     16'($urandom), 1'($urandom_range(0, 2) != 0));
        do_cycle(1'b1, 16'h5A5A, 1'b0);
        do_cycle(1'b1, 16'h3C3C, 1'b1);
        #2 reset = 1'b1;
        q.delete();
        #1;
        chk("t6_async_empty", 32'(empty), 32'(1));
        chk("t6_async_full", 32'(full), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        check_status();
        for (int i = 0; i < 60; i++)
            do_cycle(1'($urandom_range(0, 1)),
                     16'($urandom), 1'($urandom_range(0, 1)));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
